pcie_rc_link_seq: RTL and testbench
===================================

# pcie_rc_link_seq

PCIe root-complex link bring-up sequencer for the OneTSwitch 7045 PCIe RC design. It sits in the top level between the PS-generated system reset, the PCIe core's debug MMCM lock and link status, and the board's M.2/mini-PCIe sideband pins. It takes over direct driving of `pcie_perst_b` and `pcie_w_disable_b` from the system reset. It enforces the refclk-stable and PERST# hold times, watches for link-up with a timeout, retries a bounded number of times, and reports status for LEDs and software.

## Interface
- `LOCK_STABLE_CYC`, 1250: cycles of continuous MMCM lock required before the PERST# hold begins (10 us at 125 MHz).
- `PERST_HOLD_CYC`, 12_500_000: cycles PERST# is held asserted after lock is stable (100 ms).
- `LINKUP_TIMEOUT_CYC`, 125_000_000: cycles allowed after PERST# release for link-up (1 s).
- `MAX_RETRIES`, 3: PERST# re-pulses allowed after a timeout before entering FAIL.
- `CNT_W`, 28: width of the shared timer. Must hold the largest of the three cycle parameters.
- `clk`  in  1  sequencer clock (`bd_fclk0_125m`).
- `rst`  in  1  synchronous, active-high reset.
- `sys_rstn_i`  in  1  PS system reset (`bd_sys_rstn`), active low, asynchronous.
- `mmcm_lock_i`  in  1  PCIe core MMCM lock, asynchronous.
- `link_up_i`  in  1  PCIe core user link-up, asynchronous.
- `wake_b_i`  in  1  board WAKE#, active low, asynchronous.
- `retrain_i`  in  1  single-cycle software request to re-pulse PERST#.
- `perst_b_o`  out  1  PERST# to the slot, active low.
- `w_disable_b_o`  out  1  W_DISABLE# to the slot, active low.
- `state_o`  out  3  current state encoding.
- `link_ok_o`  out  1  high while in LINK_UP.
- `fail_o`  out  1  high while in FAIL.
- `retry_cnt_o`  out  2  timeouts consumed in the current attempt; saturates.
- `drop_cnt_o`  out  8  link drops since reset; saturating.

## Operation
- Input synchronisation: `sys_rstn_i`, `mmcm_lock_i`, `link_up_i` and `wake_b_i` each pass through a 2-flop synchroniser to give `*_s`. `retrain_i` is already in the `clk` domain.
- States: IDLE=0, WAIT_LOCK=1, PERST_HOLD=2, WAIT_LINK=3, LINK_UP=4, FAIL=6. Encodings 5 and 7 are unused; an illegal state recovers to IDLE.
- Transition priority, highest first:
  1. `rst` goes to IDLE.
  2. `sys_rstn_s`=0 goes to IDLE.
  3. `mmcm_lock_s`=0 in any state except IDLE and FAIL goes to WAIT_LOCK.
  4. State-specific rules below.
- IDLE: `perst_b_o`=0, `w_disable_b_o`=0. Timer, retry count and drop count are held at 0. When `sys_rstn_s`=1, go to WAIT_LOCK.
- WAIT_LOCK: `perst_b_o`=0, `w_disable_b_o`=1.
  - Timer increments while `mmcm_lock_s`=1 and clears to 0 while it is 0.
  - When timer = `LOCK_STABLE_CYC`-1 with lock high, go to PERST_HOLD and clear the timer.
- PERST_HOLD: `perst_b_o`=0. At timer = `PERST_HOLD_CYC`-1, go to WAIT_LINK and clear the timer.
- WAIT_LINK: `perst_b_o`=1.
  - `link_up_s`=1 goes to LINK_UP.
  - Otherwise, at timer = `LINKUP_TIMEOUT_CYC`-1:
    - if retry count = `MAX_RETRIES`, go to FAIL;
    - else increment retry count and go to PERST_HOLD with the timer cleared.
  - Link-up in the same cycle as the timeout wins.
- LINK_UP: `perst_b_o`=1, `link_ok_o`=1, retry count cleared to 0.
  - `link_up_s`=0: increment drop count (saturating at 255) and go to PERST_HOLD.
  - `retrain_i`=1: go to PERST_HOLD; drop count unchanged.
  - A link drop in the same cycle as `retrain_i` counts as a drop.
- FAIL: `perst_b_o`=0, `fail_o`=1, timer idle.
  - `retrain_i`=1, or a falling edge on `wake_b_s`, clears the retry count and goes to WAIT_LOCK.
  - Lock loss is ignored in FAIL.
- Entering PERST_HOLD from any state always clears the timer. PERST# is therefore always held for the full `PERST_HOLD_CYC`.
- `w_disable_b_o` is 1 in every state except IDLE.

## Timing
- All outputs are registered and change in the cycle the new state is visible on `state_o`.
- Output reset values: `perst_b_o`=0, `w_disable_b_o`=0, `state_o`=0, `link_ok_o`=0, `fail_o`=0, `retry_cnt_o`=0, `drop_cnt_o`=0.
- Latency from an asynchronous input edge to the state change is 3 cycles: 2 synchroniser cycles plus 1 register cycle.
- Latency from `retrain_i` to the state change is 1 cycle.
- PERST# low time in PERST_HOLD is exactly `PERST_HOLD_CYC` cycles.
- Minimum time from `sys_rstn_s` rising (lock already high) to PERST# rising is 1 + `LOCK_STABLE_CYC` + `PERST_HOLD_CYC` cycles.
- `rst` mid-sequence drives all outputs to their reset values on the next edge. No partial-count carry-over.

## Test plan
Parameters for all scenarios: `LOCK_STABLE_CYC`=10, `PERST_HOLD_CYC`=100, `LINKUP_TIMEOUT_CYC`=200, `MAX_RETRIES`=2.
- Nominal bring-up: release `rst`, `sys_rstn_i`=1, lock=1, raise `link_up_i` 50 cycles after PERST# rises.
  - `perst_b_o` rises 113 cycles after `sys_rstn_i` (2 sync + 1 + 10 + 100).
  - `link_ok_o`=1 three cycles after link-up.
  - `retry_cnt_o`=0.
- Retry exhaustion: link never comes up.
  - Three PERST# high windows of 200 cycles, separated by 100-cycle low pulses.
  - `retry_cnt_o` steps 1, 2.
  - Then `fail_o`=1, `state_o`=6, `perst_b_o`=0.
- Lock glitch: drop lock for 5 cycles at hold count 50.
  - Returns to WAIT_LOCK.
  - PERST# stays low for a further full 10 + 100 cycles after lock recovers.
- Link drop and retrain:
  - In LINK_UP, drop `link_up_i` for 1 cycle: `drop_cnt_o`=1, PERST# low for 100 cycles.
  - Later, pulse `retrain_i`: `drop_cnt_o` stays 1, and there is a second 100-cycle low pulse.
- FAIL recovery: in FAIL, pull `wake_b_i` low → WAIT_LOCK, `retry_cnt_o`=0, `fail_o`=0 three cycles later.
- Reset and boundary cases:
  - Assert `rst` during WAIT_LINK → all outputs at reset values next cycle.
  - `link_up_i` arriving exactly at the timeout cycle → LINK_UP, not a retry.

Source files
------------

// File: rtl/pcie_rc_link_seq.sv
// pcie_rc_link_seq
// PCIe root-complex link bring-up sequencer. It owns PERST# and W_DISABLE# to
// the slot, enforces the refclk-stable and PERST# hold times, watches for
// link-up with a timeout, and retries a bounded number of times before parking
// in FAIL. One shared timer serves every timed state. Every output is
// registered and changes on the same edge as state_o.

module pcie_rc_link_seq #(
    parameter int unsigned LOCK_STABLE_CYC    = 1250,
    parameter int unsigned PERST_HOLD_CYC     = 12_500_000,
    parameter int unsigned LINKUP_TIMEOUT_CYC = 125_000_000,
    parameter int unsigned MAX_RETRIES        = 3,
    parameter int unsigned CNT_W              = 28
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sys_rstn_i,
    input  logic       mmcm_lock_i,
    input  logic       link_up_i,
    input  logic       wake_b_i,
    input  logic       retrain_i,
    output logic       perst_b_o,
    output logic       w_disable_b_o,
    output logic [2:0] state_o,
    output logic       link_ok_o,
    output logic       fail_o,
    output logic [1:0] retry_cnt_o,
    output logic [7:0] drop_cnt_o
);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_LOCK  = 3'd1,
        ST_PERST_HOLD = 3'd2,
        ST_WAIT_LINK  = 3'd3,
        ST_LINK_UP    = 3'd4,
        ST_FAIL       = 3'd6
    } state_t;

    // The timer runs 0..N-1, so each timed state compares against N-1.
    localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_STABLE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(PERST_HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] LINK_LAST  = CNT_W'(LINKUP_TIMEOUT_CYC - 1);
    localparam logic [1:0]       RETRY_LAST = 2'(MAX_RETRIES);

    logic [1:0]       sys_rstn_sync;
    logic [1:0]       lock_sync;
    logic [1:0]       link_sync;
    logic [1:0]       wake_sync;
    logic             sys_rstn_s;
    logic             mmcm_lock_s;
    logic             link_up_s;
    logic             wake_b_s;
    logic             wake_b_q;
    logic             wake_fall;
    logic             lock_guarded;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] timer_q;
    logic [CNT_W-1:0] timer_d;
    logic [1:0]       retry_q;
    logic [1:0]       retry_d;
    logic [7:0]       drop_q;
    logic [7:0]       drop_d;

    // Two-flop synchronisers for the asynchronous inputs, plus a delayed copy of WAKE# for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            sys_rstn_sync <= 2'b00;
            lock_sync     <= 2'b00;
            link_sync     <= 2'b00;
            wake_sync     <= 2'b11;
            wake_b_q      <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments let each flop sample the previous stage's old value, forming a real shift chain.
            sys_rstn_sync <= {sys_rstn_sync[0], sys_rstn_i};
            lock_sync     <= {lock_sync[0], mmcm_lock_i};
            link_sync     <= {link_sync[0], link_up_i};
            wake_sync     <= {wake_sync[0], wake_b_i};
            wake_b_q      <= wake_b_s;
        end
    end

    assign sys_rstn_s  = sys_rstn_sync[1];
    assign mmcm_lock_s = lock_sync[1];
    assign link_up_s   = link_sync[1];
    assign wake_b_s    = wake_sync[1];
    assign wake_fall   = wake_b_q & ~wake_b_s;

    // Next-state, timer and counter logic, in priority order: system reset, lock loss, then per-state rules.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can leave one unassigned and infer a latch.
        state_d      = state_q;
        timer_d      = timer_q;
        retry_d      = retry_q;
        drop_d       = drop_q;
        lock_guarded = (state_q == ST_WAIT_LOCK) || (state_q == ST_PERST_HOLD) ||
                       (state_q == ST_WAIT_LINK) || (state_q == ST_LINK_UP);

        if (!sys_rstn_s) begin
            state_d = ST_IDLE;
            timer_d = '0;
            retry_d = '0;
            drop_d  = '0;
        end else if (lock_guarded && !mmcm_lock_s) begin
            state_d = ST_WAIT_LOCK;
            timer_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_WAIT_LOCK;
                    timer_d = '0;
                    retry_d = '0;
                    drop_d  = '0;
                end
                ST_WAIT_LOCK: begin
                    // Lock is known high here; a low lock was handled above and clears the timer.
                    if (timer_q == LOCK_LAST) begin
                        state_d = ST_PERST_HOLD;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                ST_PERST_HOLD: begin
                    if (timer_q == HOLD_LAST) begin
                        state_d = ST_WAIT_LINK;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                ST_WAIT_LINK: begin
                    // Link-up is tested first so it wins over a coincident timeout.
                    if (link_up_s) begin
                        state_d = ST_LINK_UP;
                        timer_d = '0;
                        retry_d = '0;
                    end else if (timer_q == LINK_LAST) begin
                        timer_d = '0;
                        if (retry_q == RETRY_LAST) begin
                            state_d = ST_FAIL;
                        end else begin
                            state_d = ST_PERST_HOLD;
                            retry_d = (retry_q == 2'b11) ? retry_q : retry_q + 1'b1;
                        end
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                ST_LINK_UP: begin
                    retry_d = '0;
                    // A drop is tested first so a coincident retrain still counts as a drop.
                    if (!link_up_s) begin
                        state_d = ST_PERST_HOLD;
                        timer_d = '0;
                        drop_d  = (drop_q == 8'hFF) ? drop_q : drop_q + 1'b1;
                    end else if (retrain_i) begin
                        state_d = ST_PERST_HOLD;
                        timer_d = '0;
                    end
                end
                ST_FAIL: begin
                    timer_d = '0;
                    if (retrain_i || wake_fall) begin
                        state_d = ST_WAIT_LOCK;
                        retry_d = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                    retry_d = '0;
                    drop_d  = '0;
                end
            endcase
        end
    end

    // State, timer and counters, with the slot and status outputs decoded from the next state so they change with state_o.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            timer_q       <= '0;
            retry_q       <= '0;
            drop_q        <= '0;
            perst_b_o     <= 1'b0;
            w_disable_b_o <= 1'b0;
            link_ok_o     <= 1'b0;
            fail_o        <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            retry_q       <= retry_d;
            drop_q        <= drop_d;
            perst_b_o     <= (state_d == ST_WAIT_LINK) || (state_d == ST_LINK_UP);
            w_disable_b_o <= (state_d != ST_IDLE);
            link_ok_o     <= (state_d == ST_LINK_UP);
            fail_o        <= (state_d == ST_FAIL);
        end
    end

    assign state_o     = state_q;
    assign retry_cnt_o = retry_q;
    assign drop_cnt_o  = drop_q;

endmodule

// File: tb/tb_pcie_rc_link_seq.sv
// tb_pcie_rc_link_seq
// Scoreboard bench for the link bring-up sequencer. The stimulus process works
// out, from the sequencing rules, the cycle on which each output change must
// appear and queues the expected output vector. A separate monitor pops one
// entry every time the DUT outputs change and compares cycle and values.

module tb_pcie_rc_link_seq;

    localparam int LCK = 10;
    localparam int HLD = 100;
    localparam int TMO = 200;
    localparam int MR  = 2;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WLOCK = 3'd1;
    localparam logic [2:0] S_HOLD  = 3'd2;
    localparam logic [2:0] S_WLINK = 3'd3;
    localparam logic [2:0] S_UP    = 3'd4;
    localparam logic [2:0] S_FAIL  = 3'd6;

    logic       clk = 1'b0;
    logic       rst;
    logic       sys_rstn_i;
    logic       mmcm_lock_i;
    logic       link_up_i;
    logic       wake_b_i;
    logic       retrain_i;
    logic       perst_b_o;
    logic       w_disable_b_o;
    logic [2:0] state_o;
    logic       link_ok_o;
    logic       fail_o;
    logic [1:0] retry_cnt_o;
    logic [7:0] drop_cnt_o;

    pcie_rc_link_seq #(
        .LOCK_STABLE_CYC    (LCK),
        .PERST_HOLD_CYC     (HLD),
        .LINKUP_TIMEOUT_CYC (TMO),
        .MAX_RETRIES        (MR),
        .CNT_W              (28)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .sys_rstn_i    (sys_rstn_i),
        .mmcm_lock_i   (mmcm_lock_i),
        .link_up_i     (link_up_i),
        .wake_b_i      (wake_b_i),
        .retrain_i     (retrain_i),
        .perst_b_o     (perst_b_o),
        .w_disable_b_o (w_disable_b_o),
        .state_o       (state_o),
        .link_ok_o     (link_ok_o),
        .fail_o        (fail_o),
        .retry_cnt_o   (retry_cnt_o),
        .drop_cnt_o    (drop_cnt_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [16:0] vec;
    } ev_t;

    ev_t         sb[$];
    ev_t         mon_ev;
    logic [16:0] prev_vec = '0;
    logic [16:0] cur_vec;
    bit          mon_en = 1'b0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          m_retry = 0;
    int          m_drop = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected output vector for a state, from the per-state output table.
    function automatic logic [16:0] exp_vec(input logic [2:0] st, input int retry, input int drop);
        logic perst;
        logic wdis;
        logic ok;
        logic fl;
        perst = (st == S_WLINK) || (st == S_UP);
        wdis  = (st != S_IDLE);
        ok    = (st == S_UP);
        fl    = (st == S_FAIL);
        return {st, perst, wdis, ok, fl, 2'(retry), 8'(drop)};
    endfunction

    task automatic expect_at(input int c, input logic [2:0] st);
        ev_t e;
        e.cyc = c;
        e.vec = exp_vec(st, m_retry, m_drop);
        sb.push_back(e);
    endtask

    task automatic bump_drop();
        m_drop = (m_drop < 255) ? m_drop + 1 : 255;
    endtask

    // Returns just after the posedge on which cyc becomes c.
    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Link goes down for good from LINK_UP; PERST# re-pulses until the retries run out.
    task automatic run_exhaustion(input int t, output int f);
        int p;
        wait_until(t);
        link_up_i = 1'b0;
        bump_drop();
        expect_at(t + 3, S_HOLD);
        p = t + 3 + HLD;
        expect_at(p, S_WLINK);
        f = -1;
        while (f < 0) begin
            if (m_retry == MR) begin
                f = p + TMO;
                expect_at(f, S_FAIL);
            end else begin
                m_retry++;
                expect_at(p + TMO, S_HOLD);
                p = p + TMO + HLD;
                expect_at(p, S_WLINK);
            end
        end
    endtask

    // Monitor: every change of the DUT outputs consumes one scoreboard entry.
    always @(negedge clk) begin
        if (mon_en) begin
            cur_vec = {state_o, perst_b_o, w_disable_b_o, link_ok_o, fail_o, retry_cnt_o, drop_cnt_o};
            if (cur_vec !== prev_vec) begin
                if (sb.size() == 0) begin
                    check("unexpected_change", 32'(cur_vec), 32'(prev_vec));
                end else begin
                    mon_ev = sb.pop_front();
                    check("event_cycle", cyc, mon_ev.cyc);
                    check("event_state", 32'(state_o), 32'(mon_ev.vec[16:14]));
                    check("event_outputs", 32'(cur_vec), 32'(mon_ev.vec));
                end
                prev_vec = cur_vec;
            end
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                mon_ev = sb.pop_front();
                check("missed_event", cyc, mon_ev.cyc);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int p;
        int h;
        int lu;
        int f;
        int w;
        int g;
        int r;
        int u;
        int y;
        int q;

        rst         = 1'b1;
        sys_rstn_i  = 1'b0;
        mmcm_lock_i = 1'b0;
        link_up_i   = 1'b0;
        wake_b_i    = 1'b1;
        retrain_i   = 1'b0;

        repeat (4) @(posedge clk);
        @(negedge clk);
        check("rst_state",    32'(state_o),       32'(S_IDLE));
        check("rst_perst",    32'(perst_b_o),     0);
        check("rst_wdisable", 32'(w_disable_b_o), 0);
        check("rst_link_ok",  32'(link_ok_o),     0);
        check("rst_fail",     32'(fail_o),        0);
        check("rst_retry",    32'(retry_cnt_o),   0);
        check("rst_drop",     32'(drop_cnt_o),    0);

        @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;

        // Nominal bring-up: PERST# rises 2 + 1 + LCK + HLD cycles after system reset release.
        wait_until(cyc + 3);
        t0 = cyc;
        sys_rstn_i  = 1'b1;
        mmcm_lock_i = 1'b1;
        expect_at(t0 + 3, S_WLOCK);
        h = t0 + 3 + LCK;
        expect_at(h, S_HOLD);
        p = h + HLD;
        expect_at(p, S_WLINK);
        wait_until(p + 50);
        link_up_i = 1'b1;
        expect_at(p + 53, S_UP);
        lu = p + 53;

        // Link drop, retrain, coincident drop+retrain, then random rounds.
        for (int rnd = 0; rnd < 6; rnd++) begin
            int kind;
            int t;
            kind = (rnd < 3) ? rnd : int'($urandom_range(0, 2));
            t = lu + int'($urandom_range(5, 40));
            wait_until(t);
            if (kind == 0) begin
                link_up_i = 1'b0;
                bump_drop();
                expect_at(t + 3, S_HOLD);
                wait_until(t + 1);
                link_up_i = 1'b1;
                expect_at(t + 3 + HLD, S_WLINK);
                expect_at(t + 4 + HLD, S_UP);
                lu = t + 4 + HLD;
            end else if (kind == 1) begin
                retrain_i = 1'b1;
                expect_at(t + 1, S_HOLD);
                wait_until(t + 1);
                retrain_i = 1'b0;
                expect_at(t + 1 + HLD, S_WLINK);
                expect_at(t + 2 + HLD, S_UP);
                lu = t + 2 + HLD;
            end else begin
                link_up_i = 1'b0;
                bump_drop();
                expect_at(t + 3, S_HOLD);
                wait_until(t + 1);
                link_up_i = 1'b1;
                wait_until(t + 2);
                retrain_i = 1'b1;
                wait_until(t + 3);
                retrain_i = 1'b0;
                expect_at(t + 3 + HLD, S_WLINK);
                expect_at(t + 4 + HLD, S_UP);
                lu = t + 4 + HLD;
            end
        end

        // Retry exhaustion into FAIL.
        run_exhaustion(lu + int'($urandom_range(5, 40)), f);

        // FAIL recovery on a WAKE# falling edge, then a lock glitch at hold count 50.
        w = f + int'($urandom_range(5, 30));
        wait_until(w);
        wake_b_i = 1'b0;
        m_retry = 0;
        expect_at(w + 3, S_WLOCK);
        h = w + 3 + LCK;
        expect_at(h, S_HOLD);
        wait_until(w + 8);
        wake_b_i = 1'b1;
        g = h + 50;
        wait_until(g);
        mmcm_lock_i = 1'b0;
        expect_at(g + 3, S_WLOCK);
        wait_until(g + 5);
        mmcm_lock_i = 1'b1;
        h = g + 7 + LCK;
        expect_at(h, S_HOLD);
        p = h + HLD;
        expect_at(p, S_WLINK);

        // Link-up seen on exactly the timeout cycle wins over a retry.
        wait_until(p + TMO - 3);
        link_up_i = 1'b1;
        expect_at(p + TMO, S_UP);
        lu = p + TMO;

        // Second exhaustion; lock loss in FAIL is ignored; retrain recovers.
        run_exhaustion(lu + int'($urandom_range(5, 40)), f);
        wait_until(f + 5);
        mmcm_lock_i = 1'b0;
        wait_until(f + 10);
        mmcm_lock_i = 1'b1;
        r = f + 20;
        wait_until(r);
        retrain_i = 1'b1;
        m_retry = 0;
        expect_at(r + 1, S_WLOCK);
        wait_until(r + 1);
        retrain_i = 1'b0;
        h = r + 1 + LCK;
        expect_at(h, S_HOLD);
        p = h + HLD;
        expect_at(p, S_WLINK);
        u = p + int'($urandom_range(10, 60));
        wait_until(u);
        link_up_i = 1'b1;
        expect_at(u + 3, S_UP);

        // Loss of system reset returns to IDLE and clears the counters.
        y = u + 3 + int'($urandom_range(5, 30));
        wait_until(y);
        sys_rstn_i = 1'b0;
        link_up_i  = 1'b0;
        m_retry = 0;
        m_drop  = 0;
        expect_at(y + 3, S_IDLE);
        wait_until(y + 10);
        sys_rstn_i = 1'b1;
        expect_at(y + 13, S_WLOCK);
        h = y + 13 + LCK;
        expect_at(h, S_HOLD);
        p = h + HLD;
        expect_at(p, S_WLINK);

        // rst during WAIT_LINK: reset values on the next edge, fresh timing afterwards.
        q = p + int'($urandom_range(10, 150));
        wait_until(q);
        rst        = 1'b1;
        sys_rstn_i = 1'b0;
        expect_at(q + 1, S_IDLE);
        wait_until(q + 3);
        rst = 1'b0;
        wait_until(q + 8);
        sys_rstn_i = 1'b1;
        expect_at(q + 11, S_WLOCK);
        expect_at(q + 11 + LCK, S_HOLD);

        wait_until(q + 11 + LCK + 20);
        check("scoreboard_drained", 32'(sb.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
